// File: rtl/fft_npoint_iter_if.sv
// rtl/fft_npoint_iter_if.sv - start/done handshake plus sample and result buses for fft_npoint_iter
interface fft_npoint_iter_if #(
  parameter int N     = 16,
  parameter int WIDTH = 36
);
  logic             start;
  logic             inverse;
  logic [WIDTH-1:0] inputs  [0:N-1];
  logic [WIDTH-1:0] outputs [0:N-1];
  logic             done;
  logic             busy;
  logic             overflow;

  modport master (output start, inverse, inputs, input outputs, done, busy, overflow);
  modport slave  (input start, inverse, inputs, output outputs, done, busy, overflow);
endinterface

// File: rtl/fft_npoint_iter.sv
// rtl/fft_npoint_iter.sv - iterative radix-2 DIT FFT/IFFT, one full stage of N/2 butterflies per clock
module fft_npoint_iter #(
  parameter int N     = 16,
  parameter int LOG2N = 4,
  parameter int WIDTH = 36,
  parameter int SCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  fft_npoint_iter_if.slave bus
);
  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * H + 1;
  localparam logic signed [PW-1:0]  RND    = PW'(64'sd1 << (H - 2));
  localparam logic signed [H+1:0]   MAXV   = (H+2)'((64'sd1 << (H - 1)) - 1);
  localparam logic signed [H+1:0]   MINV   = (H+2)'(-(64'sd1 << (H - 1)));
  localparam logic [LOG2N-1:0]      S_LAST = LOG2N'(LOG2N - 1);

  if (N < 4 || N > 64 || (1 << LOG2N) != N) begin : g_bad_params
    $error("fft_npoint_iter: N must be a power of two in 4..64 and LOG2N must equal log2(N)");
  end

  typedef logic signed [H-1:0] half_t;
  typedef enum logic [1:0] {IDLE, STAGE, DONE} state_t;

  // Twiddle W_N^k = cos - j*sin, rounded; +1.0 clips to the largest positive code.
  function automatic half_t tw_const(input int k, input bit imag_part);
    real    ang;
    real    v;
    longint q;
    ang = 6.283185307179586 * real'(k) / real'(N);
    v   = imag_part ? -$sin(ang) : $cos(ang);
    q   = longint'(v * (2.0 ** (H - 1)));
    if (q > (64'sd1 << (H - 1)) - 1) q = (64'sd1 << (H - 1)) - 1;
    return half_t'(q);
  endfunction

  function automatic logic [LOG2N-1:0] bitrev(input int i);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) r[b] = i[LOG2N-1-b];
    return r;
  endfunction

  // Returns {saturated, value} for one H+2 bit butterfly sum.
  function automatic logic [H:0] finish_sum(input logic signed [H+1:0] v);
    if (SCALE != 0)   return {1'b0, v[H:1]};
    else if (v > MAXV) return {1'b1, MAXV[H-1:0]};
    else if (v < MINV) return {1'b1, MINV[H-1:0]};
    else               return {1'b0, v[H-1:0]};
  endfunction

  half_t tw_re [N/2];
  half_t tw_im [N/2];
  for (genvar g = 0; g < N / 2; g++) begin : g_tw
    assign tw_re[g] = tw_const(g, 1'b0);
    assign tw_im[g] = tw_const(g, 1'b1);
  end

  state_t           state;
  logic [LOG2N-1:0] s;
  logic             inv_q;
  half_t            wre [N];
  half_t            wim [N];
  half_t            nre [N];
  half_t            nim [N];
  logic             stage_ovf;

  always_comb begin
    logic signed [PW-1:0] br, bi, wr, wi, pr, pi;
    logic signed [H+1:0]  ar, ai, bwr, bwi;
    logic [H:0]           f0r, f0i, f1r, f1i;
    logic [LOG2N-1:0]     ia, ib;
    logic [LOG2N-2:0]     tk;
    int                   sh, kk;
    nre       = wre;
    nim       = wim;
    stage_ovf = 1'b0;
    sh        = int'(s);
    for (int b = 0; b < N / 2; b++) begin
      kk  = b & ((1 << sh) - 1);
      ia  = LOG2N'(((b >> sh) << (sh + 1)) + kk);
      ib  = LOG2N'(int'(ia) + (1 << sh));
      tk  = (LOG2N-1)'(kk << (LOG2N - 1 - sh));
      ar  = (H+2)'(wre[ia]);
      ai  = (H+2)'(wim[ia]);
      br  = PW'(wre[ib]);
      bi  = PW'(wim[ib]);
      wr  = PW'(tw_re[tk]);
      wi  = inv_q ? -PW'(tw_im[tk]) : PW'(tw_im[tk]);
      pr  = (br * wr - bi * wi + RND) >>> (H - 1);
      pi  = (br * wi + bi * wr + RND) >>> (H - 1);
      bwr = pr[H+1:0];
      bwi = pi[H+1:0];
      f0r = finish_sum(ar + bwr);
      f0i = finish_sum(ai + bwi);
      f1r = finish_sum(ar - bwr);
      f1i = finish_sum(ai - bwi);
      nre[ia] = f0r[H-1:0];
      nim[ia] = f0i[H-1:0];
      nre[ib] = f1r[H-1:0];
      nim[ib] = f1i[H-1:0];
      stage_ovf = stage_ovf | f0r[H] | f0i[H] | f1r[H] | f1i[H];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      inv_q        <= 1'b0;
      bus.done     <= 1'b0;
      bus.busy     <= 1'b0;
      bus.overflow <= 1'b0;
      for (int i = 0; i < N; i++) bus.outputs[i] <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          for (int i = 0; i < N; i++) begin
            wre[bitrev(i)] <= bus.inputs[i][WIDTH-1:H];
            wim[bitrev(i)] <= bus.inputs[i][H-1:0];
          end
          inv_q        <= bus.inverse;
          bus.overflow <= 1'b0;
          s            <= '0;
          bus.busy     <= 1'b1;
          state        <= STAGE;
        end
        STAGE: begin
          wre <= nre;
          wim <= nim;
          if (stage_ovf) bus.overflow <= 1'b1;
          if (s == S_LAST) begin
            for (int i = 0; i < N; i++) bus.outputs[i] <= {nre[i], nim[i]};
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= DONE;
          end else begin
            s <= s + LOG2N'(1);
          end
        end
        DONE: if (!bus.start) begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
